// File: rtl/simplepiano_pkg.sv
// -----------------------------------------------------------------------------
// simplepiano_pkg
// Shared constants and types for the piano datapath: silence code, key count,
// octave width and the arpeggiator state encoding.
// -----------------------------------------------------------------------------
package simplepiano_pkg;

    localparam logic [3:0] NOTE_SILENT = 4'hF;
    localparam int         NUM_KEYS    = 12;
    localparam int         OCT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } arp_state_t;

endpackage

// File: rtl/arp_scheduler_if.sv
// -----------------------------------------------------------------------------
// arp_scheduler_if
// Control/output bundle of the arpeggiator.
//   en          : 1 = arpeggiate, 0 = mono pass-through of lowest held key
//   keys        : key levels, 1 = held
//   octave_base : base octave
//   dwell       : ticks per note (0 behaves as 1)
//   gap         : silent ticks between notes (0 = legato)
//   note        : note index 0..11, 4'hF = silence
//   octave      : octave for the note lookup
//   step        : one-cycle pulse at the start of each arpeggio note
//   busy        : high while a note or gap is being played
// master = key register / controller side, slave = arp_scheduler.
// -----------------------------------------------------------------------------
interface arp_scheduler_if #(
    parameter int NUM_KEYS = simplepiano_pkg::NUM_KEYS
);

    logic                              en;
    logic [NUM_KEYS-1:0]               keys;
    logic [2:0]                        octave_base;
    logic [3:0]                        dwell;
    logic [1:0]                        gap;
    logic [3:0]                        note;
    logic [simplepiano_pkg::OCT_W-1:0] octave;
    logic                              step;
    logic                              busy;

    modport master (
        output en, keys, octave_base, dwell, gap,
        input  note, octave, step, busy
    );

    modport slave (
        input  en, keys, octave_base, dwell, gap,
        output note, octave, step, busy
    );

endinterface

// File: rtl/arp_scheduler_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running counter 0..PRESCALE-1; tick is high while the count sits at
// PRESCALE-1. clr restarts the count at 0 on the next edge.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   clr  : synchronous restart
//   tick : one cycle in every PRESCALE
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRESCALE   = 10000,
    parameter int PRESCALE_W = 14
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/arp_scheduler.sv
// -----------------------------------------------------------------------------
// arp_scheduler
// Arpeggiator: steps round-robin through the held keys at a rate set by the
// prescaler tick, dwell and gap, or passes the lowest held key through when
// en = 0. All outputs are registered.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : arp_scheduler_if.slave (en, keys, octave_base, dwell, gap in;
//          note, octave, step, busy out)
// Optional feature macro: ARP_OCTAVE_SPAN_EN -- alternate the octave up by one
// each time the arpeggio wraps back to a lower key (saturating at 7).
// -----------------------------------------------------------------------------
module arp_scheduler #(
    parameter int NUM_KEYS   = simplepiano_pkg::NUM_KEYS,
    parameter int PRESCALE   = 10000,
    parameter int PRESCALE_W = 14
) (
    input  logic           clk,
    input  logic           rstn,
    arp_scheduler_if.slave bus
);

    import simplepiano_pkg::*;

    // Lowest held index, or silence when nothing is held.
    function automatic logic [3:0] f_lowest(input logic [NUM_KEYS-1:0] k);
        logic [3:0] idx;
        logic       found;
        idx   = NOTE_SILENT;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i] && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Lowest held index strictly above p, wrapping to the lowest held overall.
    function automatic logic [3:0] f_next(input logic [NUM_KEYS-1:0] k,
                                          input logic [3:0]          p);
        logic [3:0] idx;
        logic       found;
        idx   = f_lowest(k);
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i] && (i > 32'(p)) && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

`ifdef ARP_OCTAVE_SPAN_EN
    // True when no held key lies above p, i.e. the next step wraps around
    // (a single held key counts as a wrap onto itself).
    function automatic logic f_wraps(input logic [NUM_KEYS-1:0] k,
                                     input logic [3:0]          p);
        logic above;
        above = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i] && (i > 32'(p))) begin
                above = 1'b1;
            end
        end
        return !above;
    endfunction
`endif

    arp_state_t          r_state;
    arp_state_t          w_state_n;
    logic [NUM_KEYS-1:0] r_keys_q;
    logic [3:0]          r_ptr;
    logic [3:0]          w_ptr_n;
    logic [3:0]          r_dcnt;
    logic [3:0]          w_dcnt_n;
    logic [1:0]          r_gcnt;
    logic [1:0]          w_gcnt_n;

    logic [3:0]          r_note;
    logic [OCT_W-1:0]    r_octave;
    logic                r_step;
    logic                r_busy;
    logic [3:0]          w_note_n;
    logic [OCT_W-1:0]    w_octave_n;
    logic                w_step_n;
    logic                w_busy_n;

    logic                w_tick;
    logic                w_clr;
    logic                w_exit;
    logic                w_advance;
    logic [3:0]          w_dwell_last;
    logic [1:0]          w_gap_last;

`ifdef ARP_OCTAVE_SPAN_EN
    logic                r_span;
    logic                w_span_n;
    logic [OCT_W-1:0]    w_oct_sum;
`endif

    tick_prescaler #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_clr),
        .tick (w_tick)
    );

    assign w_dwell_last = (bus.dwell == '0) ? '0 : (bus.dwell - 4'd1);
    assign w_gap_last   = bus.gap - 2'd1;
    assign w_exit       = (r_keys_q == '0) || !bus.en;

    // Next-state logic; w_advance marks a move onto the next key.
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_dcnt_n  = r_dcnt;
        w_gcnt_n  = r_gcnt;
        w_step_n  = 1'b0;
        w_clr     = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en && (r_keys_q != '0)) begin
                    w_state_n = PLAY;
                    w_ptr_n   = f_lowest(r_keys_q);
                    w_dcnt_n  = '0;
                    w_clr     = 1'b1;
                    w_step_n  = 1'b1;
                end
            end
            PLAY: begin
                if (w_exit) begin
                    w_state_n = IDLE;
                end else if (w_tick) begin
                    if (r_dcnt == w_dwell_last) begin
                        if (bus.gap == '0) begin
                            w_advance = 1'b1;
                        end else begin
                            w_state_n = GAP;
                            w_gcnt_n  = '0;
                        end
                    end else begin
                        w_dcnt_n = r_dcnt + 4'd1;
                    end
                end
            end
            GAP: begin
                if (w_exit) begin
                    w_state_n = IDLE;
                end else if (w_tick) begin
                    if (r_gcnt == w_gap_last) begin
                        w_advance = 1'b1;
                    end else begin
                        w_gcnt_n = r_gcnt + 2'd1;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (w_advance) begin
            w_state_n = PLAY;
            w_ptr_n   = f_next(r_keys_q, r_ptr);
            w_dcnt_n  = '0;
            w_step_n  = 1'b1;
        end
    end

`ifdef ARP_OCTAVE_SPAN_EN
    always_comb begin
        w_span_n = r_span;
        if ((r_state == IDLE) && (w_state_n == PLAY)) begin
            w_span_n = 1'b0;
        end else if (w_advance && f_wraps(r_keys_q, r_ptr)) begin
            w_span_n = !r_span;
        end
    end

    assign w_oct_sum = {1'b0, bus.octave_base} + {{(OCT_W-1){1'b0}}, w_span_n};
`endif

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        w_note_n   = NOTE_SILENT;
        w_busy_n   = 1'b0;
        w_octave_n = {1'b0, bus.octave_base};
        case (w_state_n)
            IDLE: w_note_n = bus.en ? NOTE_SILENT : f_lowest(r_keys_q);
            PLAY: begin
                w_note_n = w_ptr_n;
                w_busy_n = 1'b1;
`ifdef ARP_OCTAVE_SPAN_EN
                w_octave_n = (w_oct_sum > OCT_W'(7)) ? OCT_W'(7) : w_oct_sum;
`endif
            end
            GAP: begin
                w_busy_n = 1'b1;
`ifdef ARP_OCTAVE_SPAN_EN
                w_octave_n = (w_oct_sum > OCT_W'(7)) ? OCT_W'(7) : w_oct_sum;
`endif
            end
            default: w_note_n = NOTE_SILENT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_keys_q <= '0;
            r_ptr    <= '0;
            r_dcnt   <= '0;
            r_gcnt   <= '0;
            r_note   <= NOTE_SILENT;
            r_octave <= '0;
            r_step   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_keys_q <= bus.keys;
            r_ptr    <= w_ptr_n;
            r_dcnt   <= w_dcnt_n;
            r_gcnt   <= w_gcnt_n;
            r_note   <= w_note_n;
            r_octave <= w_octave_n;
            r_step   <= w_step_n;
            r_busy   <= w_busy_n;
        end
    end

`ifdef ARP_OCTAVE_SPAN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_span <= 1'b0;
        end else begin
            r_span <= w_span_n;
        end
    end
`endif

    assign bus.note   = r_note;
    assign bus.octave = r_octave;
    assign bus.step   = r_step;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_arp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_arp_scheduler
// Directed bench for arp_scheduler with PRESCALE = 4. A cycle-countdown model
// of the arpeggiator predicts every output; a negedge process compares the DUT
// against it, and hand-computed literal checks pin the model at key points.
// Honours ARP_OCTAVE_SPAN_EN when defined.
// -----------------------------------------------------------------------------
module tb_arp_scheduler;

    localparam int P = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    arp_scheduler_if #(.NUM_KEYS(12)) bus ();

    arp_scheduler #(
        .NUM_KEYS   (12),
        .PRESCALE   (P),
        .PRESCALE_W (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_lowest(input logic [11:0] k);
        for (int i = 0; i < 12; i++) if (k[i]) return i;
        return 15;
    endfunction

    function automatic int m_above(input logic [11:0] k, input int p);
        for (int i = p + 1; i < 12; i++) if (k[i]) return i;
        return -1;
    endfunction

    logic [11:0] m_kq;
    int          m_mode;   // 0 idle, 1 play, 2 gap
    int          m_ptr;
    int          m_left;   // cycles left in the current note or gap
    int          m_span;
    logic [3:0]  e_note;
    logic [3:0]  e_oct;
    logic        e_step;
    logic        e_busy;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_kq = '0; m_mode = 0; m_ptr = 0; m_left = 0; m_span = 0;
            e_note = 4'hF; e_oct = 4'h0; e_step = 1'b0; e_busy = 1'b0;
        end else begin
            logic [11:0] kq;
            int d, a, o;
            kq     = m_kq;
            m_kq   = bus.keys;
            d      = (bus.dwell == 0) ? 1 : int'(bus.dwell);
            e_step = 1'b0;
            if (m_mode != 0 && (kq == 0 || !bus.en)) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (bus.en && kq != 0) begin
                    m_mode = 1; m_ptr = m_lowest(kq); m_left = d * P;
                    m_span = 0; e_step = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_mode == 1 && bus.gap != 0) begin
                        m_mode = 2; m_left = int'(bus.gap) * P;
                    end else begin
                        a = m_above(kq, m_ptr);
                        if (a >= 0) m_ptr = a;
                        else begin m_ptr = m_lowest(kq); m_span ^= 1; end
                        m_mode = 1; m_left = d * P; e_step = 1'b1;
                    end
                end
            end
            o = int'(bus.octave_base);
`ifdef ARP_OCTAVE_SPAN_EN
            if (m_mode != 0) o = (o + m_span > 7) ? 7 : o + m_span;
`endif
            e_oct  = 4'(o);
            e_busy = (m_mode != 0);
            if (m_mode == 1)      e_note = 4'(m_ptr);
            else if (m_mode == 2) e_note = 4'hF;
            else                  e_note = (bus.en || kq == 0) ? 4'hF : 4'(m_lowest(kq));
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_step = 1'b0;
    always @(negedge clk) begin
        if (rstn) begin
            chk("note",   32'(bus.note),   32'(e_note));
            chk("octave", 32'(bus.octave), 32'(e_oct));
            chk("step",   32'(bus.step),   32'(e_step));
            chk("busy",   32'(bus.busy),   32'(e_busy));
            chk("step_back_to_back", 32'(bus.step & prev_step), 32'd0);
            prev_step = bus.step;
        end else begin
            prev_step = 1'b0;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.en = 1'b0; bus.keys = '0; bus.octave_base = 3'd3;
        bus.dwell = 4'd2; bus.gap = 2'd0;

        cyc(3);
        chk("rst_note",   32'(bus.note),   32'hF);
        chk("rst_octave", 32'(bus.octave), 32'h0);
        chk("rst_busy",   32'(bus.busy),   32'h0);
        chk("rst_step",   32'(bus.step),   32'h0);
        rstn = 1'b1;
        cyc(2);
        chk("idle_octave", 32'(bus.octave), 32'd3);

        // arpeggio {0,4,7}, dwell 2, legato
        bus.en = 1'b1; bus.keys = 12'h091;
        cyc(1);
        chk("latency_k1_note", 32'(bus.note), 32'hF);
        chk("latency_k1_step", 32'(bus.step), 32'd0);
        cyc(1);
        chk("first_note", 32'(bus.note), 32'd0);
        chk("first_step", 32'(bus.step), 32'd1);
        chk("first_busy", 32'(bus.busy), 32'd1);
        cyc(8); chk("seq_4", 32'(bus.note), 32'd4); chk("seq_4_step", 32'(bus.step), 32'd1);
        cyc(8); chk("seq_7", 32'(bus.note), 32'd7);
        cyc(8); chk("seq_0", 32'(bus.note), 32'd0);
        cyc(1); chk("step_one_cycle", 32'(bus.step), 32'd0);

        // gap = 1
        bus.en = 1'b0;
        cyc(1);
        chk("mono_after_drop", 32'(bus.note), 32'd0);
        chk("busy_after_drop", 32'(bus.busy), 32'd0);
        bus.gap = 2'd1;
        cyc(1);
        bus.en = 1'b1;
        cyc(1); chk("gap_n0", 32'(bus.note), 32'd0);
        cyc(8); chk("gap_f0", 32'(bus.note), 32'hF); chk("gap_busy", 32'(bus.busy), 32'd1);
        cyc(4); chk("gap_n4", 32'(bus.note), 32'd4);
        cyc(8); chk("gap_f1", 32'(bus.note), 32'hF);
        cyc(4); chk("gap_n7", 32'(bus.note), 32'd7);

        // release key 4 while it plays
        bus.en = 1'b0; bus.gap = 2'd0;
        cyc(2);
        bus.en = 1'b1;
        cyc(1); chk("rel_n0", 32'(bus.note), 32'd0);
        cyc(8); chk("rel_n4", 32'(bus.note), 32'd4);
        cyc(2); bus.keys = 12'h081;
        cyc(6); chk("rel_n7", 32'(bus.note), 32'd7);
        cyc(8); chk("rel_wrap0", 32'(bus.note), 32'd0);
        cyc(2); bus.keys = 12'h000;
        cyc(1); chk("rel_all_k1_busy", 32'(bus.busy), 32'd1);
        cyc(1); chk("rel_all_note", 32'(bus.note), 32'hF);
        chk("rel_all_busy", 32'(bus.busy), 32'd0);

        // mono pass-through {5,9}
        bus.en = 1'b0; bus.keys = 12'h220;
        cyc(2); chk("mono_note", 32'(bus.note), 32'd5);
        cyc(10); chk("mono_note_hold", 32'(bus.note), 32'd5);
        bus.en = 1'b1;
        cyc(5); chk("play_busy", 32'(bus.busy), 32'd1);
        bus.en = 1'b0;
        cyc(1); chk("en_drop_busy", 32'(bus.busy), 32'd0);
        chk("en_drop_note", 32'(bus.note), 32'd5);

        // dwell 0 behaves as dwell 1
        bus.dwell = 4'd0; bus.en = 1'b1;
        cyc(1); chk("d0_n5", 32'(bus.note), 32'd5);
        cyc(4); chk("d0_n9", 32'(bus.note), 32'd9);
        cyc(4); chk("d0_n5b", 32'(bus.note), 32'd5);
        bus.en = 1'b0; bus.dwell = 4'd1;
        cyc(2); bus.en = 1'b1;
        cyc(1); chk("d1_n5", 32'(bus.note), 32'd5);
        cyc(4); chk("d1_n9", 32'(bus.note), 32'd9);

        // single key re-strike
        bus.en = 1'b0; bus.keys = 12'h020;
        cyc(2); bus.en = 1'b1;
        cyc(1); chk("single_step0", 32'(bus.step), 32'd1);
        cyc(1); chk("single_step_low", 32'(bus.step), 32'd0);
        cyc(3); chk("single_restrike", 32'(bus.step), 32'd1);
        chk("single_note", 32'(bus.note), 32'd5);

        // octave behaviour, keys {2,3}
        bus.en = 1'b0; bus.keys = 12'h00C; bus.octave_base = 3'd7;
        cyc(2); bus.en = 1'b1;
        cyc(1); chk("sat_oct_a", 32'(bus.octave), 32'd7);
        cyc(4); chk("sat_oct_b", 32'(bus.octave), 32'd7);
        cyc(4); chk("sat_oct_c", 32'(bus.octave), 32'd7); chk("sat_note", 32'(bus.note), 32'd2);
        bus.en = 1'b0; bus.octave_base = 3'd3;
        cyc(2); bus.en = 1'b1;
        cyc(1); chk("span_o2", 32'(bus.octave), 32'd3);
        cyc(4); chk("span_o3", 32'(bus.octave), 32'd3);
`ifdef ARP_OCTAVE_SPAN_EN
        cyc(4); chk("span_hi2", 32'(bus.octave), 32'd4);
        cyc(4); chk("span_hi3", 32'(bus.octave), 32'd4);
`else
        cyc(4); chk("span_hi2", 32'(bus.octave), 32'd3);
        cyc(4); chk("span_hi3", 32'(bus.octave), 32'd3);
`endif
        cyc(4); chk("span_back", 32'(bus.octave), 32'd3);

        // asynchronous reset mid-note
        cyc(1);
        #2 rstn = 1'b0;
        #1;
        chk("async_note",   32'(bus.note),   32'hF);
        chk("async_octave", 32'(bus.octave), 32'h0);
        chk("async_step",   32'(bus.step),   32'h0);
        chk("async_busy",   32'(bus.busy),   32'h0);
        cyc(2);
        rstn = 1'b1;
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arp_scheduler.md
# arp_scheduler

Time-multiplexes a single tone generator between all currently held piano keys by stepping round-robin through them at a programmable rate (arpeggiator). Sits between the 12-key input register and the note/octave mux that feeds the note lookup table. Drives note, octave and a step strobe; the note lookup, tone generator and LED bar downstream are unchanged.

## Interface
- NUM_KEYS, 12: number of key inputs; key index i plays note i.
- PRESCALE, 10000: clk cycles per scheduler tick; must be at least 2.
- PRESCALE_W, 14: prescaler counter width; 2^PRESCALE_W must be at least PRESCALE.
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  1 = arpeggiate; 0 = mono pass-through of the lowest held key.
- keys  in  NUM_KEYS  key levels, 1 = held.
- octave_base  in  3  base octave.
- dwell  in  4  ticks per note; 0 is treated as 1.
- gap  in  2  silent ticks between notes; 0 = legato.
- note  out  4  note index 0..11; 4'hF = silence.
- octave  out  4  octave for the note lookup.
- step  out  1  one-cycle pulse on the first cycle of each new arpeggio note.
- busy  out  1  1 while in PLAY or GAP.

## Operation
- keys_q is a registered copy of keys. All decisions use keys_q.
- The FSM uses ptr[3:0], dcnt[3:0] and gcnt[1:0].
- "Next" means the lowest set index of keys_q strictly greater than ptr, wrapping to the lowest set index overall.
- IDLE:
  - Outputs: note = lowest set index of keys_q, or F if none; octave = {0, octave_base}; busy = 0.
  - If en is 1 and keys_q is nonzero: load ptr = lowest set index, clear the prescaler and dcnt, pulse step, go to PLAY.
  - When en is 1, note stays F in IDLE.
- PLAY:
  - Outputs: note = ptr.
  - On each tick, dcnt increments.
  - When dcnt equals max(dwell,1)−1 on a tick and gap = 0: ptr = next, dcnt = 0, pulse step, stay in PLAY.
  - When dcnt equals max(dwell,1)−1 on a tick and gap > 0: go to GAP with gcnt = 0.
- GAP:
  - Outputs: note = F.
  - On each tick, gcnt increments.
  - When gcnt equals gap−1 on a tick: ptr = next, dcnt = 0, pulse step, go to PLAY.
- From PLAY or GAP, go to IDLE if either holds:
  - keys_q is 0; this takes priority over a tick in the same cycle.
  - en is 0.
- If the current key is released while other keys are held, the note still plays to the end of its dwell.
- With a single held key, next returns the same index: the note re-strikes and step pulses.
- Changes to dwell or gap apply at the next comparison; there is no latching.
- Octave: {1'b0, octave_base}, except as modified under Configuration.

## Timing
- Reset values: note = 4'hF, octave = 4'h0, step = 0, busy = 0; state IDLE, ptr = 0, all counters 0.
- An asynchronous reset asserted mid-note forces these values immediately.
- All outputs are registered.
- A key change at edge k appears in keys_q at k+1. A note change and the step pulse follow at k+2.
- The prescaler runs freely, 0..PRESCALE−1. It emits tick when the count equals PRESCALE−1.
- Note length in PLAY = max(dwell,1)·PRESCALE cycles. Gap length = gap·PRESCALE cycles.
- step is never high in two consecutive cycles.

## Configuration
- ARP_OCTAVE_SPAN_EN defined:
  - Add a span register, reset to 0 and cleared on IDLE→PLAY.
  - span toggles whenever next wraps to a lower index, including the single-key case.
  - octave = min({0, octave_base} + span, 7).
- ARP_OCTAVE_SPAN_EN undefined: there is no span register, and octave = {0, octave_base} at all times.

## Structure
- Shared package simplepiano_pkg holds:
  - NOTE_SILENT = 4'hF
  - NUM_KEYS = 12
  - the state enum (IDLE, PLAY, GAP)
  - the octave width constant
- One sub-module: tick_prescaler, with ports clk, rstn, clr, tick. It is parameterised by PRESCALE and PRESCALE_W.
- Next-index selection is a combinational function inside arp_scheduler.

## Test plan
Benches use PRESCALE = 4.
- Reset with keys = 0 → note = F, octave = 0, busy = 0, step = 0. Assert rstn low mid-PLAY → outputs return to reset values with no clock edge.
- en = 1, dwell = 2, gap = 0, octave_base = 3, keys = {0,4,7}:
  - note sequence 0,4,7,0,… with each note lasting 8 cycles and step pulsing every 8 cycles;
  - the first note appears 2 cycles after keys are applied.
- Same keys, gap = 1 → note pattern 0 (8 cycles), F (4 cycles), 4 (8 cycles), F (4 cycles), …
- Release key 4 while note 4 is playing, keeping keys 0 and 7 → 4 finishes its dwell, then 7, then 0. Release all keys → note = F and busy = 0 two cycles after the release.
- en = 0, keys = {5,9} → note = 5, step never pulses. Drop en while in PLAY → IDLE the next cycle. dwell = 0 behaves exactly as dwell = 1.
- ARP_OCTAVE_SPAN_EN defined, octave_base = 7, keys = {2,3} → octave stays 7 (saturated). With octave_base = 3 → octave is 3 for notes 2,3, then 4 for notes 2,3, then 3 again.
